// File: rtl/imem_load_controller.sv
// Boot/reload sequencer: streams a program into instruction memory, holds the core
// in reset for a fixed window, then releases fetch.
module imem_load_controller #(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned HOLD_CYC  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        s_valid,
  input  logic [31:0]                 s_data,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic                        imem_we,
  output logic                        imem_wr,
  output logic [31:0]                 imem_addr,
  output logic [31:0]                 imem_wdata,
  output logic                        core_hold,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [$clog2(MAX_WORDS):0]  word_count
);

  localparam int unsigned CW = $clog2(MAX_WORDS) + 1;
  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StLoad      = 3'd1;
  localparam logic [2:0] StWriteLast = 3'd2;
  localparam logic [2:0] StHold      = 3'd3;
  localparam logic [2:0] StRun       = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] count_q, count_d;
  logic          error_q, error_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          accept;
  logic          at_cap;

  assign s_ready = (state_q == StLoad);
  assign accept  = s_valid & s_ready;
  assign at_cap  = (count_q == CW'(MAX_WORDS - 1));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    count_d = count_q;
    error_d = error_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    case (state_q)
      StIdle, StRun: begin
        if (start) begin
          state_d = StLoad;
          count_d = '0;
          error_d = 1'b0;
        end
      end
      StLoad: begin
        if (accept) begin
          wr_d    = 1'b1;
          wdata_d = s_data;
          addr_d  = 32'(count_q) << 2;
          count_d = count_q + CW'(1);
          if (s_last) begin
            state_d = StWriteLast;
          end else if (at_cap) begin
            // Memory full without an end marker: keep the write, flag it, stay held.
            state_d = StIdle;
            error_d = 1'b1;
          end
        end
      end
      StWriteLast: begin
        state_d = StHold;
        hold_d  = HW'(HOLD_CYC - 1);
      end
      StHold: begin
        if (hold_q == '0) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      hold_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      error_q <= error_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // A pending strobe keeps load mode on, so the overflow write lands even after leaving LOAD.
  assign imem_we    = (state_q == StLoad) || (state_q == StWriteLast) || wr_q;
  assign imem_wr    = wr_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_hold  = (state_q != StRun);
  assign busy       = (state_q == StLoad) || (state_q == StWriteLast) || (state_q == StHold);
  assign done       = (state_q == StRun);
  assign error      = error_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_load_controller.sv
// Self-checking bench for imem_load_controller: directed boot/reload scenarios plus
// randomized program streams checked against a simple word-index model.
module tb_imem_load_controller;

  localparam int unsigned MW = 4;
  localparam int unsigned HC = 2;
  localparam int unsigned CW = $clog2(MW) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_ready, imem_we, imem_wr, core_hold, busy, done, error;
  logic [31:0]   imem_addr, imem_wdata;
  logic [CW-1:0] word_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_cnt = 0;
  int we_viol = 0;
  logic [31:0] words [MW];
  logic [31:0] mem [MW];

  imem_load_controller #(
    .MAX_WORDS(MW),
    .HOLD_CYC (HC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .imem_we   (imem_we),
    .imem_wr   (imem_wr),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Memory image and write-enable protocol as seen by the instruction memory.
  always @(posedge clk) begin
    if (imem_wr) begin
      wr_cnt <= wr_cnt + 1;
      if (!imem_we) we_viol <= we_viol + 1;
      mem[imem_addr[$clog2(MW)+1:2]] <= imem_wdata;
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Stream n words from words[]; model: word i lands at byte address 4*i one cycle
  // after its handshake, then WRITE_LAST, HC hold cycles, RUN (or overflow to idle).
  task automatic stream(input int n, input bit term, input bit gaps, input string tag);
    int i = 0;
    int acc_idx = 0;
    bit prev_acc = 1'b0;
    int cyc = 0;
    while (i < n && cyc < 300) begin
      total_cnt++;
      if ({imem_wr, s_ready, imem_we, core_hold, busy, done, error, word_count} !==
          {prev_acc, 6'b111100, CW'(i)})
        $display("FAIL %s load_flags cyc %0d: got %b want %b", tag, cyc,
                 {imem_wr, s_ready, imem_we, core_hold, busy, done, error, word_count},
                 {prev_acc, 6'b111100, CW'(i)});
      else pass_cnt++;
      if (prev_acc) begin
        total_cnt++;
        if ({imem_addr, imem_wdata} !== {32'(acc_idx * 4), words[acc_idx]})
          $display("FAIL %s write_%0d: got addr %h data %h want addr %h data %h", tag, acc_idx,
                   imem_addr, imem_wdata, 32'(acc_idx * 4), words[acc_idx]);
        else pass_cnt++;
      end
      s_valid = !gaps || ($urandom_range(0, 2) == 0);
      s_data  = s_valid ? words[i] : $urandom();
      s_last  = s_valid ? (term && (i == n - 1)) : 1'($urandom_range(0, 1));
      prev_acc = s_valid;
      if (s_valid) begin
        acc_idx = i;
        i++;
      end
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (i < n) begin
      total_cnt++;
      $display("FAIL %s timeout: accepted %0d want %0d", tag, i, n);
    end
    total_cnt++;
    if ({imem_wr, imem_we, s_ready, core_hold, busy, done, error, word_count, imem_addr,
         imem_wdata} !== {3'b110, 1'b1, term, 1'b0, !term, CW'(n), 32'((n - 1) * 4),
                          words[n - 1]})
      $display("FAIL %s final_write: got %b/%h/%h want %b/%h/%h", tag,
               {imem_wr, imem_we, s_ready, core_hold, busy, done, error, word_count},
               imem_addr, imem_wdata, {3'b110, 1'b1, term, 1'b0, !term, CW'(n)},
               32'((n - 1) * 4), words[n - 1]);
    else pass_cnt++;
    @(negedge clk);
    if (term) begin
      repeat (HC) begin
        total_cnt++;
        if ({imem_wr, imem_we, s_ready, core_hold, busy, done} !== 6'b000110)
          $display("FAIL %s hold: got %b want %b", tag,
                   {imem_wr, imem_we, s_ready, core_hold, busy, done}, 6'b000110);
        else pass_cnt++;
        @(negedge clk);
      end
      total_cnt++;
      if ({imem_we, imem_wr, s_ready, core_hold, busy, done, error, word_count} !==
          {7'b0000010, CW'(n)})
        $display("FAIL %s run: got %b want %b", tag,
                 {imem_we, imem_wr, s_ready, core_hold, busy, done, error, word_count},
                 {7'b0000010, CW'(n)});
      else pass_cnt++;
    end else begin
      total_cnt++;
      if ({imem_we, imem_wr, s_ready, core_hold, busy, done, error, word_count} !==
          {7'b0001001, CW'(n)})
        $display("FAIL %s overflow_idle: got %b want %b", tag,
                 {imem_we, imem_wr, s_ready, core_hold, busy, done, error, word_count},
                 {7'b0001001, CW'(n)});
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({s_ready, imem_we, imem_wr, core_hold, busy, done, error} !== 7'b0001000 ||
        {imem_addr, imem_wdata, word_count} !== '0)
      $display("FAIL reset_values: got %b %h %h %0d want 0001000 0 0 0",
               {s_ready, imem_we, imem_wr, core_hold, busy, done, error},
               imem_addr, imem_wdata, word_count);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    words[0] = 32'h00500093;
    words[1] = 32'h00100113;
    words[2] = 32'h002081B3;
    do_start();
    stream(3, 1'b1, 1'b0, "basic");
  endtask

  task automatic test_reset_mid_run();
    int w;
    #2 rst = 1'b0;
    w = wr_cnt;
    #1;
    total_cnt++;
    if ({s_ready, imem_we, imem_wr, core_hold, busy, done, error} !== 7'b0001000 ||
        {imem_addr, imem_wdata, word_count} !== '0)
      $display("FAIL reset_mid_run: got %b %h %h %0d want 0001000 0 0 0",
               {s_ready, imem_we, imem_wr, core_hold, busy, done, error},
               imem_addr, imem_wdata, word_count);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({s_ready, imem_we, imem_wr, core_hold, busy, done} !== 6'b000100 || wr_cnt != w)
      $display("FAIL idle_after_reset: got %b writes %0d want 000100 writes %0d",
               {s_ready, imem_we, imem_wr, core_hold, busy, done}, wr_cnt, w);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    int w = wr_cnt;
    do_start();
    stream(3, 1'b1, 1'b1, "gaps");
    total_cnt++;
    if (mem[0] !== 32'h00500093 || mem[1] !== 32'h00100113 || mem[2] !== 32'h002081B3 ||
        wr_cnt != w + 3)
      $display("FAIL gaps_image: got %h %h %h writes %0d want 00500093 00100113 002081b3 %0d",
               mem[0], mem[1], mem[2], wr_cnt - w, 3);
    else pass_cnt++;
  endtask

  task automatic test_reload_from_run();
    words[0] = $urandom();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if ({core_hold, done, busy} !== 3'b101)
      $display("FAIL reload_hold: got %b want 101", {core_hold, done, busy});
    else pass_cnt++;
    stream(1, 1'b1, 1'b0, "reload");
    // Stream traffic in RUN must be ignored.
    s_valid = 1'b1;
    s_last  = 1'b1;
    repeat (3) begin
      s_data = $urandom();
      @(negedge clk);
      total_cnt++;
      if ({s_ready, imem_wr, imem_we, done} !== 4'b0001)
        $display("FAIL ignore_in_run: got %b want 0001", {s_ready, imem_wr, imem_we, done});
      else pass_cnt++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_overflow();
    for (int k = 0; k < MW; k++) words[k] = $urandom();
    do_start();
    stream(MW, 1'b0, 1'b0, "overflow");
    @(negedge clk);
    do_start();
    total_cnt++;
    if ({error, core_hold, busy, word_count} !== {3'b011, CW'(0)})
      $display("FAIL error_clear: got %b want %b", {error, core_hold, busy, word_count},
               {3'b011, CW'(0)});
    else pass_cnt++;
    stream(2, 1'b1, 1'b1, "after_overflow");
  endtask

  task automatic test_random();
    repeat (8) begin
      int n = $urandom_range(1, MW);
      bit term = (n < MW) ? 1'b1 : 1'($urandom_range(0, 1));
      int w = wr_cnt;
      for (int k = 0; k < MW; k++) words[k] = $urandom();
      do_start();
      stream(n, term, 1'($urandom_range(0, 1)), "random");
      total_cnt++;
      if (wr_cnt != w + n)
        $display("FAIL random_write_count: got %0d want %0d", wr_cnt - w, n);
      else pass_cnt++;
      for (int k = 0; k < n; k++) begin
        total_cnt++;
        if (mem[k] !== words[k])
          $display("FAIL random_image_%0d: got %h want %h", k, mem[k], words[k]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_load();
    for (int k = 0; k < MW; k++) words[k] = $urandom();
    do_start();
    s_valid = 1'b1;
    s_data  = words[0];
    @(negedge clk);
    s_data = words[1];
    @(negedge clk);
    s_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({s_ready, imem_we, imem_wr, core_hold, busy, done, error} !== 7'b0001000 ||
        {imem_addr, imem_wdata, word_count} !== '0)
      $display("FAIL reset_mid_load: got %b %h %h %0d want 0001000 0 0 0",
               {s_ready, imem_we, imem_wr, core_hold, busy, done, error},
               imem_addr, imem_wdata, word_count);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    words[0] = $urandom();
    do_start();
    stream(1, 1'b1, 1'b0, "reload_after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_run();
    test_gaps();
    test_reload_from_run();
    test_overflow();
    test_random();
    test_reset_mid_load();
    repeat (2) @(negedge clk);
    total_cnt++;
    if (we_viol != 0)
      $display("FAIL wr_without_we: got %0d strobes want 0", we_viol);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
